// File: rtl/tank_select_sequencer.sv
// Tank select sequencer: decodes a dual-rail tank address into a one-hot
// in/out gate. The gate aligns to the next minor-cycle boundary and is held
// for exactly WORD_DIGITS digit pulses.
module tank_select_sequencer #(
    parameter int ADDR_BITS   = 2,
    parameter int WORD_DIGITS = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_BITS-1:0]      addr_pos,
    input  logic [ADDR_BITS-1:0]      addr_neg,
    input  logic                      t_in_req,
    input  logic                      t_out_req,
    input  logic                      minor_start,
    input  logic                      digit_pulse,
    output logic [(2**ADDR_BITS)-1:0] tank_in,
    output logic [(2**ADDR_BITS)-1:0] tank_out,
    output logic                      busy,
    output logic                      done,
    output logic                      addr_err
);

    localparam int NT = 2**ADDR_BITS;
    localparam int CW = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(WORD_DIGITS - 1);
    localparam logic [NT-1:0] GATE_LSB   = NT'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    // Dual-rail pair is consistent only when every bit differs between rails.
    function automatic logic dual_rail_ok(input logic [ADDR_BITS-1:0] p,
                                          input logic [ADDR_BITS-1:0] n);
        return &(p ^ n);
    endfunction

    state_t               state_q,    state_d;
    logic [CW-1:0]        cnt_q,      cnt_d;
    logic [ADDR_BITS-1:0] addr_q,     addr_d;
    logic                 dir_q,      dir_d;
    logic [NT-1:0]        tank_in_q,  tank_in_d;
    logic [NT-1:0]        tank_out_q, tank_out_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 addr_err_q, addr_err_d;

    logic                 req_s;
    logic                 reject_s;
    logic [NT-1:0]        gate_s;

    assign req_s    = t_in_req | t_out_req;
    assign reject_s = ~dual_rail_ok(addr_pos, addr_neg) | (t_in_req & t_out_req);
    assign gate_s   = GATE_LSB << addr_q;

    // Next-state and next-output logic for the request/arm/transfer sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dir_d      = dir_q;
        tank_in_d  = tank_in_q;
        tank_out_d = tank_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    if (reject_s) begin
                        addr_err_d = 1'b1;
                    end else begin
                        addr_d  = addr_pos;
                        dir_d   = t_in_req;
                        busy_d  = 1'b1;
                        state_d = ST_ARMED;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ARMED: begin
                if (minor_start) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                    if (dir_q) begin
                        tank_in_d  = gate_s;
                        tank_out_d = '0;
                    end else begin
                        tank_in_d  = '0;
                        tank_out_d = gate_s;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end

            ST_XFER: begin
                if (digit_pulse) begin
                    if (cnt_q == LAST_DIGIT) begin
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                        tank_in_d  = '0;
                        tank_out_d = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                addr_d     = '0;
                dir_d      = 1'b0;
                tank_in_d  = '0;
                tank_out_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the gate immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            dir_q      <= 1'b0;
            tank_in_q  <= '0;
            tank_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            tank_in_q  <= tank_in_d;
            tank_out_q <= tank_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign tank_in  = tank_in_q;
    assign tank_out = tank_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_tank_select_sequencer.sv
// Bench for tank_select_sequencer: a 4-tank/18-digit instance checked by a
// vector table, hand sequences and a transaction-level model under random
// stimulus, plus a 32-tank/36-digit instance for the wide configuration.
module tb_tank_select_sequencer;

    localparam int WD_A = 18;
    localparam int WD_B = 36;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        minor_start, digit_pulse;
    logic [1:0]  a_pos, a_neg;
    logic        a_in_req, a_out_req;
    logic [3:0]  a_tank_in, a_tank_out;
    logic        a_busy, a_done, a_err;
    logic [4:0]  b_pos, b_neg;
    logic        b_in_req, b_out_req;
    logic [31:0] b_tank_in, b_tank_out;
    logic        b_busy, b_done, b_err;

    tank_select_sequencer #(.ADDR_BITS(2), .WORD_DIGITS(WD_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .addr_pos(a_pos), .addr_neg(a_neg),
        .t_in_req(a_in_req), .t_out_req(a_out_req),
        .minor_start(minor_start), .digit_pulse(digit_pulse),
        .tank_in(a_tank_in), .tank_out(a_tank_out),
        .busy(a_busy), .done(a_done), .addr_err(a_err));

    tank_select_sequencer #(.ADDR_BITS(5), .WORD_DIGITS(WD_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .addr_pos(b_pos), .addr_neg(b_neg),
        .t_in_req(b_in_req), .t_out_req(b_out_req),
        .minor_start(minor_start), .digit_pulse(digit_pulse),
        .tank_in(b_tank_in), .tank_out(b_tank_out),
        .busy(b_busy), .done(b_done), .addr_err(b_err));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of instance A: phase 0 = free, 1 = waiting for
    // boundary, 2 = window open with m_left pulses still to go.
    int m_phase, m_tank, m_left;
    bit m_dir, e_done, e_err;

    function automatic void model_reset();
        m_phase = 0; m_tank = 0; m_left = 0; m_dir = 1'b0;
        e_done = 1'b0; e_err = 1'b0;
    endfunction

    function automatic void model_edge();
        e_done = 1'b0;
        e_err  = 1'b0;
        if (m_phase == 0) begin
            if (a_in_req || a_out_req) begin
                if ((a_pos ^ a_neg) != 2'b11 || (a_in_req && a_out_req)) begin
                    e_err = 1'b1;
                end else begin
                    m_phase = 1; m_tank = int'(a_pos); m_dir = a_in_req;
                end
            end
        end else if (m_phase == 1) begin
            if (minor_start) begin
                m_phase = 2; m_left = WD_A;
            end
        end else if (digit_pulse) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_phase = 0; e_done = 1'b1;
            end
        end
    endfunction

    task automatic compare_model();
        logic [3:0] gate;
        gate = 4'(1 << m_tank);
        check("model_tank_in",  64'(a_tank_in),  64'((m_phase == 2 &&  m_dir) ? gate : 4'd0));
        check("model_tank_out", 64'(a_tank_out), 64'((m_phase == 2 && !m_dir) ? gate : 4'd0));
        check("model_busy",     64'(a_busy),     64'(m_phase != 0));
        check("model_done",     64'(a_done),     64'(e_done));
        check("model_addr_err", 64'(a_err),      64'(e_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [1:0] pos, neg;
        logic       in_r, out_r, ms, dp;
        logic [3:0] x_in, x_out;
        logic       x_busy, x_done, x_err;
    } vec_t;

    vec_t vecs[11];
    logic [31:0] one32;

    initial begin
        vecs[0]  = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};

        one32 = 32'd1;
        rst_n = 1'b0;
        minor_start = 1'b0; digit_pulse = 1'b0;
        a_pos = 2'b00; a_neg = 2'b11; a_in_req = 1'b0; a_out_req = 1'b0;
        b_pos = 5'd0;  b_neg = 5'h1f; b_in_req = 1'b0; b_out_req = 1'b0;
        model_reset();
        #12;
        check("reset_a_gates", 64'({a_tank_in, a_tank_out}), 64'd0);
        check("reset_a_flags", 64'({a_busy, a_done, a_err}), 64'd0);
        check("reset_b_gates", 64'({b_tank_in, b_tank_out}), 64'd0);
        check("reset_b_flags", 64'({b_busy, b_done, b_err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: rejections, acceptance, ignored strobes and requests.
        for (int i = 0; i < 11; i++) begin
            a_pos = vecs[i].pos; a_neg = vecs[i].neg;
            a_in_req = vecs[i].in_r; a_out_req = vecs[i].out_r;
            minor_start = vecs[i].ms; digit_pulse = vecs[i].dp;
            cycle();
            check("vec_tank_in",  64'(a_tank_in),  64'(vecs[i].x_in));
            check("vec_tank_out", 64'(a_tank_out), 64'(vecs[i].x_out));
            check("vec_busy",     64'(a_busy),     64'(vecs[i].x_busy));
            check("vec_done",     64'(a_done),     64'(vecs[i].x_done));
            check("vec_addr_err", 64'(a_err),      64'(vecs[i].x_err));
        end
        a_in_req = 1'b0; a_out_req = 1'b0; minor_start = 1'b0;

        // Remaining pulses 3..18 of the tank-2 write window, with gaps.
        for (int k = 3; k <= WD_A; k++) begin
            digit_pulse = 1'b1;
            cycle();
            digit_pulse = 1'b0;
            if (k < WD_A) begin
                check("win_gate_held", 64'({a_tank_in, a_tank_out}), 64'({4'b0100, 4'b0000}));
                check("win_no_done",   64'({a_busy, a_done}), 64'(2'b10));
            end else begin
                check("win_end_gate", 64'({a_tank_in, a_tank_out}), 64'd0);
                check("win_end_flag", 64'({a_busy, a_done}), 64'(2'b01));
            end
            cycle();
            if (k == WD_A) check("done_one_cycle", 64'({a_busy, a_done}), 64'd0);
        end

        // Asynchronous reset in the middle of a read window.
        a_pos = 2'b01; a_neg = 2'b10; a_out_req = 1'b1;
        cycle();
        a_out_req = 1'b0; minor_start = 1'b1;
        cycle();
        minor_start = 1'b0; digit_pulse = 1'b1;
        cycle(); cycle(); cycle();
        digit_pulse = 1'b0;
        check("pre_reset_gate", 64'(a_tank_out), 64'(4'b0010));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gate", 64'({a_tank_in, a_tank_out}), 64'd0);
        check("async_rst_flag", 64'({a_busy, a_done, a_err}), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_reset_idle", 64'(a_busy), 64'd0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            a_pos = 2'($urandom_range(0, 3));
            a_neg = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : ~a_pos;
            r = $urandom_range(0, 15);
            a_in_req  = (r == 0) || (r == 2) || (r == 3);
            a_out_req = (r == 1) || (r == 2) || (r == 4);
            minor_start = ($urandom_range(0, 9) == 0);
            digit_pulse = ($urandom_range(0, 1) == 1);
            cycle();
        end
        a_in_req = 1'b0; a_out_req = 1'b0; minor_start = 1'b0; digit_pulse = 1'b0;

        // Wide instance: read tank 31, then back-to-back write in done cycle.
        b_pos = 5'd31; b_neg = 5'd0; b_out_req = 1'b1;
        cycle();
        b_out_req = 1'b0;
        check("b_accept_busy", 64'({b_busy, b_err}), 64'(2'b10));
        check("b_accept_nogate", 64'({b_tank_in, b_tank_out}), 64'd0);
        minor_start = 1'b1;
        cycle();
        minor_start = 1'b0;
        check("b_gate_out31", 64'(b_tank_out), 64'(one32 << 31));
        check("b_gate_in0",   64'(b_tank_in),  64'd0);
        for (int k = 1; k <= WD_B; k++) begin
            digit_pulse = 1'b1;
            cycle();
            digit_pulse = 1'b0;
            if (k < WD_B) begin
                check("b_gate_held", 64'({b_tank_in, b_tank_out}), 64'({32'd0, one32 << 31}));
            end else begin
                check("b_end_gate", 64'({b_tank_in, b_tank_out}), 64'd0);
                check("b_end_flag", 64'({b_busy, b_done}), 64'(2'b01));
            end
        end
        b_pos = 5'd5; b_neg = ~5'd5; b_in_req = 1'b1;
        cycle();
        b_in_req = 1'b0;
        check("b_b2b_accept", 64'({b_busy, b_done, b_err}), 64'(3'b100));
        minor_start = 1'b1;
        cycle();
        minor_start = 1'b0;
        check("b_b2b_gate_in", 64'(b_tank_in),  64'(one32 << 5));
        check("b_b2b_gate_out", 64'(b_tank_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
